ha_array_accum_8x8: RTL and testbench

HA_ARRAY_ACCUM_8X8 -- requirements
Module: ha_array_accum_8x8

---
 rtl/ha_array_accum_8x8.sv | 115 +++++++++++
 tb/tb_ha_array_accum_8x8.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ha_array_accum_8x8.sv
// Serial accumulator for a 4-row half-adder array: one row is folded into a
// 17-bit accumulator per cycle, so a product is ready 4 cycles after acceptance.
module ha_array_accum_8x8 #(
  parameter int OUT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic [1:0]       dbg_state_o
);

  if (OUT_W < 17) begin : g_out_w_check
    $error("ha_array_accum_8x8: OUT_W must be >= 17");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [16:0]      acc_q, acc_d;
  logic [3:0][6:0]  b_q, b_d;
  logic [3:0][8:0]  t_q, t_d;

  logic [3:0][6:0]  in_b;
  logic [3:0][8:0]  in_t;
  logic [6:0]       row_b;
  logic [8:0]       row_t;
  logic [9:0]       row_val;
  logic [16:0]      row_term;
  logic             accept;

  assign in_b = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
  assign in_t = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};

  // Row value R = t + b[5:0]*4 + b[6]*256, weighted by 4^cnt.
  always_comb begin
    row_b    = b_q[cnt_q];
    row_t    = t_q[cnt_q];
    row_val  = {1'b0, row_t} + {2'b00, row_b[5:0], 2'b00} + {1'b0, row_b[6], 8'h00};
    row_term = {7'd0, row_val} << {cnt_q, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      t_q     <= t_d;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; out_valid/product stay put until that edge, and in DONE a new operand
  // set may be taken on the very edge the result is consumed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    t_d       = t_q;
    out_valid = (state_q == DONE);
    in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    accept    = in_valid & in_ready;

    if (accept) begin
      state_d = ACC;
      cnt_d   = '0;
      acc_d   = '0;
      b_d     = in_b;
      t_d     = in_t;
    end else begin
      case (state_q)
        IDLE: ;
        ACC: begin
          acc_d = acc_q + row_term;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    product       = '0;
    product[16:0] = acc_q;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ha_array_accum_8x8.sv
// Directed bench for ha_array_accum_8x8: hand-computed products, backpressure,
// mid-operation reset and a short back-to-back run with random out_ready.
module tb_ha_array_accum_8x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  vb [4];
  logic [8:0]  vt [4];
  logic        out_valid;
  logic        out_ready;
  logic [16:0] product;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  ha_array_accum_8x8 #(.OUT_W(17)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (vb[0]),
    .ha_array_1_b (vb[1]),
    .ha_array_2_b (vb[2]),
    .ha_array_3_b (vb[3]),
    .ha_array_0_t (vt[0]),
    .ha_array_1_t (vt[1]),
    .ha_array_2_t (vt[2]),
    .ha_array_3_t (vt[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input logic [27:0] bb, input logic [35:0] tt);
    for (int i = 0; i < 4; i++) begin
      vb[i] = bb[7*i +: 7];
      vt[i] = tt[9*i +: 9];
    end
  endtask

  // Independent reference: sum of (t + b[5:0]*4 + b[6]*256) * 4^r.
  function automatic logic [16:0] ref_product(input logic [27:0] bb, input logic [35:0] tt);
    int unsigned sum = 0;
    for (int r = 0; r < 4; r++) begin
      int unsigned rv;
      rv  = tt[9*r +: 9] + 4 * (bb[7*r +: 6]) + 256 * bb[7*r + 6];
      sum = sum + rv * (4 ** r);
    end
    return sum[16:0];
  endfunction

  // Accept one operand set from IDLE, scramble inputs during ACC, check the
  // 4-cycle latency, the result and the one-cycle pulse.
  task automatic run_directed(input string tag, input logic [27:0] bb,
                              input logic [35:0] tt, input logic [16:0] exp);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_rows(bb, tt);
    step();
    in_valid = 1'b0;
    set_rows('1, '1);
    check({tag, "_acc_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_ov_c0"}, 32'(out_valid), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("%s_ov_c%0d", tag, c), 32'(out_valid), 32'd0);
    end
    step();
    check({tag, "_ov_c4"}, 32'(out_valid), 32'd1);
    check({tag, "_product"}, 32'(product), 32'(exp));
    step();
    check({tag, "_pulse_end"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [27:0] rb;
    logic [35:0] rt;
    int sent, got, cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_rows('0, '0);
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_product", 32'(product), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'd0);

    run_directed("zeros",   28'h0, 36'h0, 17'd0);
    run_directed("t0_1",    28'h0, 36'h0_0000_0001, 17'd1);
    run_directed("b3_40",   {7'h40, 7'h00, 7'h00, 7'h00}, 36'h0, 17'd16384);
    run_directed("b2_01",   {7'h00, 7'h01, 7'h00, 7'h00}, 36'h0, 17'd64);
    run_directed("t1_1ff",  28'h0, {9'h000, 9'h000, 9'h1FF, 9'h000}, 17'd2044);
    run_directed("b0_3f",   {7'h00, 7'h00, 7'h00, 7'h3F}, 36'h0, 17'd252);
    run_directed("all_ones", '1, '1, 17'd86615);

    // Backpressure for 10 cycles, then consume and accept on the same edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_rows(28'h0, {9'h000, 9'h000, 9'h001, 9'h000});
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("bp_ov_rise", 32'(out_valid), 32'd1);
    check("bp_product", 32'(product), 32'd4);
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("bp_hold_ov_%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_prod_%0d", c), 32'(product), 32'd4);
      check($sformatf("bp_hold_ready_%0d", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_rows(28'h0, {9'h001, 9'h000, 9'h000, 9'h000});
    #1;
    check("bp_same_edge_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    set_rows('0, '0);
    check("bp_chain_ov", 32'(out_valid), 32'd0);
    check("bp_chain_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    check("bp_chain_ov_c3", 32'(out_valid), 32'd0);
    step();
    check("bp_chain_ov_c4", 32'(out_valid), 32'd1);
    check("bp_chain_product", 32'(product), 32'd64);
    step();
    check("bp_chain_idle", 32'(out_valid), 32'd0);

    // Reset while cnt == 2 mid-ACC; the interrupted operation must vanish.
    in_valid = 1'b1;
    set_rows('1, '1);
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ov", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("midrst_quiet_%0d", c), 32'(out_valid), 32'd0);
    end
    run_directed("after_rst", 28'h0, 36'h0_0000_0005, 17'd5);

    // Back-to-back operand sets with random out_ready.
    sent = 0; got = 0; cyc = 0;
    while ((got < 20) && (cyc < 600)) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 20);
      rb = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
      rt = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
      set_rows(rb, rt);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_product(rb, rt));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_output", 32'd1, 32'd0);
        end else begin
          check($sformatf("rand_product_%0d", got), 32'(product), 32'(exp_q.pop_front()));
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_all_received", 32'(got), 32'd20);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
